// File: rtl/seq_right_shifter.sv
// Multi-cycle right shifter: one bit per clock, logical or arithmetic, Start/Done handshake.
// Optional SEQ_SHIFT_ROTATE_EN adds a Rotate input selecting rotate-right.
module seq_right_shifter #(
   parameter int unsigned WIDTH   = 8,
   parameter int unsigned SHAMT_W = 3
) (
   input  logic               CLK,
   input  logic               Reset_n,
   input  logic               Start,
   input  logic [WIDTH-1:0]   Source,
   input  logic [SHAMT_W-1:0] Shamt,
   input  logic               Arith,
`ifdef SEQ_SHIFT_ROTATE_EN
   input  logic               Rotate,
`endif
   output logic               Busy,
   output logic               Done,
   output logic [WIDTH-1:0]   Result
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SHIFT = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;

   logic [1:0]         state_q, state_d;
   logic [WIDTH-1:0]   sreg_q, sreg_d;
   logic [SHAMT_W-1:0] cnt_q, cnt_d;
   logic               fill_q, fill_d;
   logic [WIDTH-1:0]   result_q, result_d;
   logic               accept;
   logic               msb;
   logic [WIDTH-1:0]   shifted;
`ifdef SEQ_SHIFT_ROTATE_EN
   logic               rot_q, rot_d;
`endif

   // DONE accepts like IDLE so back-to-back requests see no bubble.
   assign accept = Start && (state_q != SHIFT);

   always_comb begin
      msb = fill_q;
`ifdef SEQ_SHIFT_ROTATE_EN
      if (rot_q) msb = sreg_q[0];
`endif
      shifted = {msb, sreg_q[WIDTH-1:1]};
   end

   always_comb begin
      state_d  = state_q;
      sreg_d   = sreg_q;
      cnt_d    = cnt_q;
      fill_d   = fill_q;
      result_d = result_q;
`ifdef SEQ_SHIFT_ROTATE_EN
      rot_d    = rot_q;
`endif
      case (state_q)
         IDLE, DONE: begin
            if (accept) begin
               sreg_d = Source;
               cnt_d  = Shamt;
               fill_d = Arith & Source[WIDTH-1];
`ifdef SEQ_SHIFT_ROTATE_EN
               rot_d  = Rotate;
`endif
               if (Shamt == '0) begin
                  state_d  = DONE;
                  result_d = Source;
               end else begin
                  state_d = SHIFT;
               end
            end else begin
               state_d = IDLE;
            end
         end
         SHIFT: begin
            sreg_d = shifted;
            cnt_d  = cnt_q - SHAMT_W'(1);
            if (cnt_q == SHAMT_W'(1)) begin
               state_d  = DONE;
               result_d = shifted;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q  <= IDLE;
         sreg_q   <= '0;
         cnt_q    <= '0;
         fill_q   <= 1'b0;
         result_q <= '0;
`ifdef SEQ_SHIFT_ROTATE_EN
         rot_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         sreg_q   <= sreg_d;
         cnt_q    <= cnt_d;
         fill_q   <= fill_d;
         result_q <= result_d;
`ifdef SEQ_SHIFT_ROTATE_EN
         rot_q    <= rot_d;
`endif
      end
   end

   assign Busy   = (state_q == SHIFT);
   assign Done   = (state_q == DONE);
   assign Result = result_q;

endmodule

// File: tb/tb_seq_right_shifter.sv
// Scoreboard bench for seq_right_shifter: expected results queued at issue, checked on Done.
// Rotate cases are compiled in only when SEQ_SHIFT_ROTATE_EN is defined.
module tb_seq_right_shifter;

   logic       clk;
   logic       reset_n;
   logic       start;
   logic [7:0] source;
   logic [2:0] shamt;
   logic       arith;
`ifdef SEQ_SHIFT_ROTATE_EN
   logic       rotate;
`endif
   logic       busy;
   logic       done;
   logic [7:0] result;

   typedef struct {
      logic [7:0] res;
      int         sh;
      int         cyc;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   int   busy_cnt = 0;
   int   done_cnt = 0;
   logic [7:0] last_res = '0;

   seq_right_shifter dut (
`ifdef SEQ_SHIFT_ROTATE_EN
      .Rotate (rotate),
`endif
      .CLK    (clk),
      .Reset_n(reset_n),
      .Start  (start),
      .Source (source),
      .Shamt  (shamt),
      .Arith  (arith),
      .Busy   (busy),
      .Done   (done),
      .Result (result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] ref_shift(input logic [7:0] src, input int sh, input logic ar,
                                            input logic rot);
      logic [7:0] r;
      r = src;
      for (int i = 0; i < sh; i++) r = {(rot ? r[0] : (ar & src[7])), r[7:1]};
      return r;
   endfunction

   // Call at a falling edge; the next rising edge accepts the request.
   task automatic present(input logic [7:0] src, input int sh, input logic ar, input logic rot);
      exp_t e;
      source = src;
      shamt  = 3'(sh);
      arith  = ar;
`ifdef SEQ_SHIFT_ROTATE_EN
      rotate = rot;
`endif
      start  = 1'b1;
      e.res = ref_shift(src, sh, ar, rot);
      e.sh  = sh;
      e.cyc = cyc + 1 + sh;
      exp_q.push_back(e);
   endtask

   task automatic wait_idle();
      int n = 0;
      while (exp_q.size() != 0 && n < 40) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (exp_q.size() != 0) begin
         check_eq("timeout_pending", exp_q.size(), 0);
         exp_q.delete();
      end
   endtask

   task automatic issue(input logic [7:0] src, input int sh, input logic ar, input logic rot);
      @(negedge clk);
      present(src, sh, ar, rot);
      @(negedge clk);
      start = 1'b0;
      wait_idle();
   endtask

   // Output monitor: latency, Busy duration, result value and Result stability.
   always @(negedge clk) begin
      exp_t e;
      if (!reset_n) begin
         busy_cnt = 0;
         last_res = '0;
      end else begin
         check_eq("busy_done_exclusive", {31'b0, busy & done}, 0);
         if (busy) busy_cnt++;
         if (done) begin
            done_cnt++;
            check_eq("done_has_expectation", {31'b0, exp_q.size() != 0}, 1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check_eq("result", result, e.res);
               check_eq("done_cycle", cyc, e.cyc);
               check_eq("busy_cycles", busy_cnt, e.sh);
               busy_cnt = 0;
               last_res = e.res;
            end
         end else begin
            check_eq("result_hold", result, last_res);
         end
      end
   end

   initial begin
      int dc;
      reset_n = 1'b0;
      start   = 1'b0;
      source  = '0;
      shamt   = '0;
      arith   = 1'b0;
`ifdef SEQ_SHIFT_ROTATE_EN
      rotate  = 1'b0;
`endif
      repeat (2) @(negedge clk);
      check_eq("reset_busy", busy, 0);
      check_eq("reset_done", done, 0);
      check_eq("reset_result", result, 0);
      reset_n = 1'b1;

      // Logical shift with Start pulses during Busy that must be ignored.
      @(negedge clk);
      present(8'h80, 3, 1'b0, 1'b0);
      @(negedge clk);
      source = 8'hFF;
      shamt  = 3'd1;
      arith  = 1'b1;
      repeat (3) @(negedge clk);
      start = 1'b0;
      wait_idle();

      issue(8'h80, 3, 1'b1, 1'b0);
      issue(8'h70, 7, 1'b1, 1'b0);
      issue(8'hA5, 0, 1'b0, 1'b0);
      issue(8'hFF, 7, 1'b0, 1'b0);
      issue(8'h80, 7, 1'b1, 1'b0);
      issue(8'h7F, 7, 1'b0, 1'b0);

      // Back-to-back: second request presented on the Done cycle of the first.
      @(negedge clk);
      present(8'h40, 2, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      present(8'h08, 1, 1'b0, 1'b0);
      @(negedge clk);
      start = 1'b0;
      wait_idle();

      // Chain of random back-to-back operations with Start held high.
      @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         int sh;
         sh = $urandom_range(0, 7);
         present(8'($urandom), sh, 1'($urandom), 1'b0);
         repeat (sh + 1) @(negedge clk);
      end
      start = 1'b0;
      wait_idle();

      for (int i = 0; i < 6; i++) issue(8'($urandom), $urandom_range(0, 7), 1'($urandom), 1'b0);

`ifdef SEQ_SHIFT_ROTATE_EN
      issue(8'h81, 1, 1'b0, 1'b1);
      issue(8'h81, 4, 1'b1, 1'b1);
      issue(8'h81, 4, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) issue(8'($urandom), $urandom_range(0, 7), 1'($urandom), 1'b1);
`endif

      // Asynchronous reset two cycles into a 5-bit shift.
      issue(8'hC3, 2, 1'b0, 1'b0);
      @(negedge clk);
      present(8'hF0, 5, 1'b0, 1'b0);
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
      #2;
      check_eq("busy_before_reset", busy, 1);
      reset_n = 1'b0;
      #1;
      check_eq("midreset_busy", busy, 0);
      check_eq("midreset_done", done, 0);
      check_eq("midreset_result", result, 0);
      exp_q.delete();
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      dc = done_cnt;
      repeat (10) @(negedge clk);
      check_eq("no_done_after_reset", done_cnt, dc);
      check_eq("result_after_reset", result, 0);

      issue(8'h80, 3, 1'b0, 1'b0);
      check_eq("queue_drained", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
